fu_div: RTL
===========

FU_DIV -- requirements
Module: fu_div

Interface
REQ-001 SHALL have parameter width_p, default WORD_SIZE_P, operand/result width in bits.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port instruction_i  input  issued_instruction_t  issued op from issue table; uses source_1_data (dividend), source2_imm_data (divisor), dest_id, opcode.
REQ-005 SHALL have port valid_i  input  1  issue table presents an op for this FU.
REQ-006 SHALL have port ready_o  output  1  unit can accept an op this cycle.
REQ-007 SHALL have port flush_i  input  1  squash all in-flight and presented work.
REQ-008 SHALL have port cdb_o  output  CDB_t  result broadcast; fields valid, dest, data, exc.

Function
REQ-009 SHALL accept an op only in a cycle with valid_i & ready_o & ~flush_i, capturing operands, dest_id and opcode.
REQ-010 SHALL decode opcode[0]: 0 = quotient, 1 = remainder; opcode[1]: 0 = unsigned, 1 = signed.
REQ-011 SHALL implement FSM IDLE -> BUSY on accept; BUSY -> DONE after exactly width_p iterations; DONE -> IDLE, or DONE -> BUSY on a same-cycle accept.
REQ-012 SHALL perform one restoring-division step per BUSY cycle, using a width_p-bit iteration counter.
REQ-013 SHALL, for signed ops, divide magnitudes and then negate: quotient when operand signs differ; remainder to take the dividend's sign.
REQ-014 SHALL drive ready_o = 1 in IDLE and DONE and 0 in BUSY; ready_o forced 0 while flush_i = 1.
REQ-015 SHALL assert cdb_o.valid for exactly one cycle (DONE), exactly width_p+1 cycles after the accept cycle; cdb_o.dest = captured dest_id.
REQ-016 SHALL, on divisor = 0: quotient = all ones, remainder = dividend, exc = 1, with normal latency.
REQ-017 SHALL, on signed MIN / -1: quotient = MIN, remainder = 0, exc = 0.
REQ-018 SHALL keep exc = 0 for all other results; cdb_o.data/dest/exc = 0 whenever cdb_o.valid = 0.
REQ-019 SHALL, on flush_i in BUSY, return to IDLE next cycle with no broadcast for that op.
REQ-020 SHALL, on flush_i in DONE, mask cdb_o.valid combinationally in that cycle and go to IDLE.
REQ-021 SHALL NOT apply backpressure on the CDB; the result is never held or retried.
REQ-022 SHALL register all datapath state; cdb_o.valid is a function of state and flush_i only.

Reset
REQ-023 SHALL, while reset_i = 0, asynchronously force state IDLE, counter 0, all captured fields 0, cdb_o = 0, and ready_o = 1.
REQ-024 SHALL discard any op in flight when reset asserts mid-operation; no broadcast follows reset release.
REQ-025 SHALL accept a new op in the first cycle after reset_i deasserts.

Verification
REQ-026 SHALL cover unsigned divide (width_p = 16): accept 100 / 7, DIVU, dest 5 at cycle 0 -> cycle 17: cdb_o valid, dest 5, data 14, exc 0; ready_o low cycles 1-16.
REQ-027 SHALL cover signed remainder and overflow: REMS 0xFFF9 / 2 -> data 0xFFFF; DIVS 0x8000 / 0xFFFF -> data 0x8000, exc 0.
REQ-028 SHALL cover divide by zero: DIVU 5 / 0 -> data 0xFFFF, exc 1; REMU 5 / 0 -> data 5, exc 1; both at cycle 17.
REQ-029 SHALL cover back-to-back ops: second op presented in first op's DONE cycle is accepted -> two results 17 cycles apart, no gap.
REQ-030 SHALL cover flush: flush_i at cycle 8 of an op -> no cdb_o.valid, ready_o = 1 at cycle 9; flush_i in DONE cycle -> cdb_o.valid = 0.
REQ-031 SHALL cover reset mid-operation: reset_i low at cycle 10 -> cdb_o = 0 and ready_o = 1 immediately; no broadcast after release.

Source files
------------

// File: rtl/fu_div.sv
// fu_div: multi-cycle restoring divider functional unit.
// It takes one op from the issue table, runs width_p restoring steps, and
// broadcasts the quotient or remainder on the CDB for exactly one cycle.
// The unsigned core always divides magnitudes. Signed ops are sign-fixed once
// the last step completes.

package fu_div_pkg;
  localparam int WORD_SIZE_P = 16;
  localparam int DEST_W_P    = 6;
  localparam int OPCODE_W_P  = 2;

  // opcode[0]: 0 = quotient, 1 = remainder; opcode[1]: 0 = unsigned, 1 = signed
  typedef struct packed {
    logic [WORD_SIZE_P-1:0] source_1_data;
    logic [WORD_SIZE_P-1:0] source2_imm_data;
    logic [DEST_W_P-1:0]    dest_id;
    logic [OPCODE_W_P-1:0]  opcode;
  } issued_instruction_t;

  typedef struct packed {
    logic                   valid;
    logic [DEST_W_P-1:0]    dest;
    logic [WORD_SIZE_P-1:0] data;
    logic                   exc;
  } CDB_t;
endpackage

module fu_div
  import fu_div_pkg::*;
#(
  parameter int width_p = WORD_SIZE_P
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  issued_instruction_t instruction_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                flush_i,
  output CDB_t                cdb_o
);

  localparam logic [width_p-1:0] LAST_CNT = width_p'(width_p - 1);
  localparam logic [width_p-1:0] ONE_W    = {{(width_p-1){1'b0}}, 1'b1};
  localparam logic [width_p-1:0] ZERO_W   = {width_p{1'b0}};
  localparam logic [width_p-1:0] ALL_ONES = {width_p{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement negation, used for both operand magnitudes and result fixup.
  function automatic logic [width_p-1:0] neg2(input logic [width_p-1:0] v);
    return ~v + ONE_W;
  endfunction

  state_t               state_r, state_n;
  logic [width_p-1:0]   cnt_r;
  logic [width_p-1:0]   dend_r;      // raw dividend, returned as remainder on divide-by-zero
  logic [width_p-1:0]   dvsr_r;      // divisor magnitude
  logic [width_p-1:0]   quo_r;       // dividend bits shift out of the top, quotient bits shift in below
  logic [width_p-1:0]   rem_r;
  logic [DEST_W_P-1:0]  dest_r;
  logic                 is_rem_r, neg_quo_r, neg_rem_r, div_zero_r;
  logic [width_p-1:0]   result_r;
  logic                 exc_r;

  logic                 ready_s, accept_s, cdb_valid_s;
  logic [width_p-1:0]   src_a_s, src_b_s, a_mag_s, b_mag_s;
  logic                 a_neg_s, b_neg_s;
  logic [width_p:0]     rem_shift_s, trial_s;
  logic [width_p-1:0]   rem_next_s, quo_next_s, final_s;
  logic                 q_bit_s;

  // Operand decode: signed ops are reduced to magnitudes plus sign flags.
  always_comb begin
    src_a_s = instruction_i.source_1_data[width_p-1:0];
    src_b_s = instruction_i.source2_imm_data[width_p-1:0];
    a_neg_s = instruction_i.opcode[1] & src_a_s[width_p-1];
    b_neg_s = instruction_i.opcode[1] & src_b_s[width_p-1];
    a_mag_s = a_neg_s ? neg2(src_a_s) : src_a_s;
    b_mag_s = b_neg_s ? neg2(src_b_s) : src_b_s;
  end

  // FSM next state, handshake and broadcast qualifier.
  always_comb begin
    state_n     = state_r;
    ready_s     = (state_r != S_BUSY) & ~flush_i;
    accept_s    = valid_i & ready_s;
    cdb_valid_s = (state_r == S_DONE) & ~flush_i;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_n = S_BUSY;
        else          state_n = S_IDLE;
      end
      S_BUSY: begin
        if (flush_i)                 state_n = S_IDLE;
        else if (cnt_r == LAST_CNT)  state_n = S_DONE;
        else                         state_n = S_BUSY;
      end
      S_DONE: begin
        if (flush_i)       state_n = S_IDLE;
        else if (accept_s) state_n = S_BUSY;
        else               state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign ready_o = ready_s;

  // One restoring step. The remainder stays below the divisor, so bit width_p of the trial is the borrow.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[width_p-1]};
    trial_s     = rem_shift_s - {1'b0, dvsr_r};
    if (trial_s[width_p]) begin
      rem_next_s = rem_shift_s[width_p-1:0];
      q_bit_s    = 1'b0;
    end else begin
      rem_next_s = trial_s[width_p-1:0];
      q_bit_s    = 1'b1;
    end
    quo_next_s = {quo_r[width_p-2:0], q_bit_s};
  end

  // Final result selection: divide-by-zero override, then sign fixup of the selected magnitude.
  always_comb begin
    if (div_zero_r) begin
      final_s = is_rem_r ? dend_r : ALL_ONES;
    end else if (is_rem_r) begin
      final_s = neg_rem_r ? neg2(rem_next_s) : rem_next_s;
    end else begin
      final_s = neg_quo_r ? neg2(quo_next_s) : quo_next_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_r <= S_IDLE;
    else          state_r <= state_n;
  end

  // Datapath: capture on accept, iterate while busy, latch the result on the last step.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_r      <= ZERO_W;
      dend_r     <= ZERO_W;
      dvsr_r     <= ZERO_W;
      quo_r      <= ZERO_W;
      rem_r      <= ZERO_W;
      dest_r     <= {DEST_W_P{1'b0}};
      is_rem_r   <= 1'b0;
      neg_quo_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      result_r   <= ZERO_W;
      exc_r      <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= ZERO_W;
      dend_r     <= src_a_s;
      dvsr_r     <= b_mag_s;
      quo_r      <= a_mag_s;
      rem_r      <= ZERO_W;
      dest_r     <= instruction_i.dest_id;
      is_rem_r   <= instruction_i.opcode[0];
      neg_quo_r  <= a_neg_s ^ b_neg_s;
      neg_rem_r  <= a_neg_s;
      div_zero_r <= (src_b_s == ZERO_W);
      result_r   <= ZERO_W;
      exc_r      <= 1'b0;
    end else if ((state_r == S_BUSY) && !flush_i) begin
      quo_r <= quo_next_s;
      rem_r <= rem_next_s;
      cnt_r <= cnt_r + ONE_W;
      if (cnt_r == LAST_CNT) begin
        result_r <= final_s;
        exc_r    <= div_zero_r;
      end
    end
  end

  // CDB drive: all fields are zero unless the broadcast is valid this cycle.
  always_comb begin
    cdb_o.valid = 1'b0;
    cdb_o.dest  = {DEST_W_P{1'b0}};
    cdb_o.data  = {WORD_SIZE_P{1'b0}};
    cdb_o.exc   = 1'b0;
    if (cdb_valid_s) begin
      cdb_o.valid = 1'b1;
      cdb_o.dest  = dest_r;
      cdb_o.data  = WORD_SIZE_P'(result_r);
      cdb_o.exc   = exc_r;
    end else begin
      cdb_o.valid = 1'b0;
    end
  end

endmodule
